mem_port_arbiter: RTL and testbench

- Shares the single core memory bus between the instruction fetch requester (IF, read-only) and the load/store requester (MEM, read/write).
- One transaction is outstanding at a time. MEM has fixed priority, consistent with "later pipeline stage wins".
- A bounded anti-starvation counter guarantees IF forward progress.
- Produces the per-requester stall levels consumed by the pipeline controller (IF ram stall, MEM ram stall).

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory bus between the instruction-fetch port (IF, read only)
//   and the load/store port (MEM, read/write). One transaction in flight at a
//   time; MEM wins arbitration except when it has already taken
//   MAX_MEM_STREAK grants in a row while IF was waiting.
// Ports
//   clk, rst_n          : clock, async active-low reset
//   if_*                : IF request level / address, ack pulse, rdata, stall
//   mem_*               : MEM request level / we / address / wdata / wstrb,
//                         ack pulse, rdata, stall
//   bus_valid_o..wstrb_o: registered request towards memory
//   bus_ready_i         : request accepted
//   bus_rvalid_i/rdata_i: response (returned for both reads and writes)
module mem_port_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MAX_MEM_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req_i,
  input  logic [AW-1:0]   if_addr_i,
  output logic            if_ack_o,
  output logic [DW-1:0]   if_rdata_o,
  output logic            if_stall_o,
  input  logic            mem_req_i,
  input  logic            mem_we_i,
  input  logic [AW-1:0]   mem_addr_i,
  input  logic [DW-1:0]   mem_wdata_i,
  input  logic [DW/8-1:0] mem_wstrb_i,
  output logic            mem_ack_o,
  output logic [DW-1:0]   mem_rdata_o,
  output logic            mem_stall_o,
  output logic            bus_valid_o,
  input  logic            bus_ready_i,
  output logic            bus_we_o,
  output logic [AW-1:0]   bus_addr_o,
  output logic [DW-1:0]   bus_wdata_o,
  output logic [DW/8-1:0] bus_wstrb_o,
  input  logic            bus_rvalid_i,
  input  logic [DW-1:0]   bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_MEM_STREAK);

  state_t     state, state_nxt;
  logic       owner_mem;   // 1: MEM owns the current transaction, 0: IF
  logic [3:0] streak;      // consecutive MEM grants taken while IF waited
  logic       grant_mem, grant_if, complete;

  // Next state, grant decision and completion
  always_comb begin
    state_nxt = state;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    complete  = 1'b0;
    case (state)
      IDLE: begin
        // MEM wins unless IF has been passed over MAX_MEM_STREAK times
        if (mem_req_i && !(if_req_i && streak == STREAK_MAX)) begin
          grant_mem = 1'b1;
          state_nxt = REQ;
        end else if (if_req_i) begin
          grant_if  = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // rvalid without ready is not a response to this request
        if (bus_ready_i) begin
          if (bus_rvalid_i) begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      RESP: begin
        if (bus_rvalid_i) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Owner, streak and latched bus payload; only loaded at a grant so later
  // requester-side changes never reach the bus mid-transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_mem   <= 1'b1;
      streak      <= '0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
      bus_wstrb_o <= '0;
    end else if (grant_mem) begin
      owner_mem   <= 1'b1;
      bus_we_o    <= mem_we_i;
      bus_addr_o  <= mem_addr_i;
      bus_wdata_o <= mem_wdata_i;
      bus_wstrb_o <= mem_we_i ? mem_wstrb_i : '0;
      if (!if_req_i)                streak <= '0;
      else if (streak != STREAK_MAX) streak <= streak + 4'd1;
    end else if (grant_if) begin
      owner_mem   <= 1'b0;
      streak      <= '0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= if_addr_i;
      bus_wdata_o <= '0;
      bus_wstrb_o <= '0;
    end
  end

  assign bus_valid_o = (state == REQ);

  assign mem_ack_o   = complete &  owner_mem;
  assign if_ack_o    = complete & ~owner_mem;
  assign mem_rdata_o = owner_mem  ? bus_rdata_i : '0;
  assign if_rdata_o  = !owner_mem ? bus_rdata_i : '0;

  assign if_stall_o  = if_req_i  & ~if_ack_o;
  assign mem_stall_o = mem_req_i & ~mem_ack_o;

  // Protocol monitors (simulation only in effect)
  always @(posedge clk) begin
    if (rst_n) begin
      if (state == IDLE)
        assert (!bus_rvalid_i)
          else $warning("mem_port_arbiter: bus_rvalid_i in IDLE ignored");
      if (state != IDLE)
        assert (owner_mem ? mem_req_i : if_req_i)
          else $error("mem_port_arbiter: owner request dropped before ack");
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            if_req = 1'b0;
  logic [AW-1:0]   if_addr = '0;
  logic            if_ack;
  logic [DW-1:0]   if_rdata;
  logic            if_stall;
  logic            mem_req = 1'b0;
  logic            mem_we = 1'b0;
  logic [AW-1:0]   mem_addr = '0;
  logic [DW-1:0]   mem_wdata = '0;
  logic [DW/8-1:0] mem_wstrb = '0;
  logic            mem_ack;
  logic [DW-1:0]   mem_rdata;
  logic            mem_stall;
  logic            bus_valid;
  logic            bus_ready = 1'b0;
  logic            bus_we;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata;
  logic [DW/8-1:0] bus_wstrb;
  logic            bus_rvalid = 1'b0;
  logic [DW-1:0]   bus_rdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_MEM_STREAK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack),
    .if_rdata_o(if_rdata), .if_stall_o(if_stall),
    .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_wstrb_i(mem_wstrb), .mem_ack_o(mem_ack),
    .mem_rdata_o(mem_rdata), .mem_stall_o(mem_stall),
    .bus_valid_o(bus_valid), .bus_ready_i(bus_ready), .bus_we_o(bus_we),
    .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_wstrb_o(bus_wstrb),
    .bus_rvalid_i(bus_rvalid), .bus_rdata_i(bus_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // drive point: 1ns after the rising edge; checks are made at the falling edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic half();
    @(negedge clk);
  endtask

  initial begin
    // ---------------- reset state ----------------
    #3;
    chk("rst_valid", bus_valid, 0);
    chk("rst_we",    bus_we,    0);
    chk("rst_addr",  bus_addr,  0);
    chk("rst_wdata", bus_wdata, 0);
    chk("rst_wstrb", bus_wstrb, 0);
    chk("rst_acks",  {if_ack, mem_ack}, 0);
    #9 rst_n = 1'b1;

    // ---------------- IF-only read ----------------
    cyc(); if_req = 1; if_addr = 32'h8000_0000;
    half(); chk("t1_stall_c0", if_stall, 1); chk("t1_valid_c0", bus_valid, 0);
    cyc(); half();
    chk("t1_valid_c1", bus_valid, 1);
    chk("t1_addr",     bus_addr, 32'h8000_0000);
    chk("t1_we",       bus_we, 0);
    chk("t1_stall_c1", if_stall, 1);
    cyc(); half(); chk("t1_valid_c2", bus_valid, 1);
    cyc(); bus_ready = 1;
    half(); chk("t1_ack_c3", if_ack, 0); chk("t1_stall_c3", if_stall, 1);
    cyc(); bus_ready = 0;
    half(); chk("t1_valid_resp", bus_valid, 0); chk("t1_stall_c4", if_stall, 1);
    cyc(); half(); chk("t1_ack_c5", if_ack, 0);
    cyc(); bus_rvalid = 1; bus_rdata = 32'h0000_0013;
    half();
    chk("t1_ack",      if_ack, 1);
    chk("t1_rdata",    if_rdata, 32'h13);
    chk("t1_stall_ack", if_stall, 0);
    chk("t1_memack",   mem_ack, 0);
    cyc(); if_req = 0; bus_rvalid = 0;
    half(); chk("t1_ack_after", if_ack, 0); chk("t1_valid_idle", bus_valid, 0);

    // ---------------- simultaneous IF + MEM ----------------
    cyc(); mem_req = 1; mem_we = 0; mem_addr = 32'h2000; if_req = 1; if_addr = 32'h8000_0004;
    half(); chk("t2_stalls", {if_stall, mem_stall}, 2'b11);
    cyc(); bus_ready = 1; bus_rvalid = 1; bus_rdata = 32'hAAAA;
    half();
    chk("t2_addr_mem", bus_addr, 32'h2000);
    chk("t2_acks_mem", {if_ack, mem_ack}, 2'b01);
    chk("t2_mrdata",   mem_rdata, 32'hAAAA);
    chk("t2_irdata0",  if_rdata, 0);
    chk("t2_istall",   if_stall, 1);
    cyc(); mem_req = 0; bus_ready = 0; bus_rvalid = 0;
    half(); chk("t2_valid_gap", bus_valid, 0); chk("t2_acks_gap", {if_ack, mem_ack}, 0);
    cyc(); bus_ready = 1; bus_rvalid = 1; bus_rdata = 32'h55;
    half();
    chk("t2_addr_if", bus_addr, 32'h8000_0004);
    chk("t2_wstrb_if", bus_wstrb, 0);
    chk("t2_acks_if", {if_ack, mem_ack}, 2'b10);
    chk("t2_irdata",  if_rdata, 32'h55);
    chk("t2_mrdata0", mem_rdata, 0);
    cyc(); if_req = 0; bus_ready = 0; bus_rvalid = 0;

    // ---------------- MEM streak limit ----------------
    if_req = 1; if_addr = 32'h8000_0008; mem_req = 1; mem_we = 0; mem_addr = 32'h3000;
    half(); chk("t3_valid0", bus_valid, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(); bus_ready = 1; bus_rvalid = 1; bus_rdata = 32'(k);
      half();
      chk("t3_mem_addr", bus_addr, 32'h3000 + 32'(4 * k));
      chk("t3_mem_acks", {if_ack, mem_ack}, 2'b01);
      cyc(); bus_ready = 0; bus_rvalid = 0; mem_addr = 32'h3000 + 32'(4 * (k + 1));
      half(); chk("t3_valid_idle", bus_valid, 0);
    end
    cyc(); bus_ready = 1; bus_rvalid = 1; bus_rdata = 32'h77;
    half();
    chk("t3_if_addr",  bus_addr, 32'h8000_0008);
    chk("t3_if_acks",  {if_ack, mem_ack}, 2'b10);
    chk("t3_mstall",   mem_stall, 1);
    cyc(); if_req = 0; bus_ready = 0; bus_rvalid = 0;
    cyc(); bus_ready = 1; bus_rvalid = 1;
    half(); chk("t3_mem_after", bus_addr, 32'h3010); chk("t3_mack_after", mem_ack, 1);
    cyc(); mem_req = 0; bus_ready = 0; bus_rvalid = 0;

    // -------- streak restarted: 4 more MEM grants before IF --------
    if_req = 1; if_addr = 32'h8000_000C; mem_req = 1; mem_addr = 32'h3100;
    for (int k = 0; k < 4; k++) begin
      cyc(); bus_ready = 1; bus_rvalid = 1;
      half(); chk("t3b_mem_acks", {if_ack, mem_ack}, 2'b01);
      cyc(); bus_ready = 0; bus_rvalid = 0;
    end
    cyc(); bus_ready = 1; bus_rvalid = 1;
    half(); chk("t3b_if_acks", {if_ack, mem_ack}, 2'b10);
    cyc(); if_req = 0; mem_req = 0; bus_ready = 0; bus_rvalid = 0;

    // ---------------- MEM write, payload changes after grant ----------------
    cyc(); mem_req = 1; mem_we = 1; mem_addr = 32'h1000; mem_wdata = 32'hDEAD_BEEF; mem_wstrb = 4'b0011;
    cyc(); mem_wdata = 0; mem_wstrb = 4'b1111; mem_addr = 32'hFFFF;
    half();
    chk("t4_wdata", bus_wdata, 32'hDEAD_BEEF);
    chk("t4_wstrb", bus_wstrb, 4'b0011);
    chk("t4_we",    bus_we, 1);
    chk("t4_addr",  bus_addr, 32'h1000);
    cyc(); bus_rvalid = 1;
    half();
    chk("t4_rvalid_no_ready", mem_ack, 0);
    chk("t4_wdata_hold", bus_wdata, 32'hDEAD_BEEF);
    cyc(); bus_rvalid = 0; bus_ready = 1;
    half(); chk("t4_wstrb_ready", bus_wstrb, 4'b0011); chk("t4_mstall", mem_stall, 1);
    cyc(); bus_ready = 0;
    half(); chk("t4_valid_resp", bus_valid, 0);
    cyc(); bus_rvalid = 1; bus_rdata = 0;
    half(); chk("t4_ack", mem_ack, 1); chk("t4_mstall_ack", mem_stall, 0);
    cyc(); mem_req = 0; mem_we = 0; bus_rvalid = 0;

    // ---------------- reset during RESP ----------------
    cyc(); if_req = 1; if_addr = 32'h8000_0010;
    cyc(); bus_ready = 1;
    cyc(); bus_ready = 0;
    half(); chk("t6_in_resp", bus_valid, 0);
    #2 rst_n = 0; if_req = 0;
    #1 chk("t6_rst_addr", bus_addr, 0);
    bus_rvalid = 1; bus_rdata = 32'h99;
    #1 chk("t6_rst_acks", {if_ack, mem_ack}, 0);
    cyc(); cyc(); rst_n = 1;
    half(); chk("t6_late_acks", {if_ack, mem_ack}, 0); chk("t6_late_valid", bus_valid, 0);
    cyc(); bus_rvalid = 0; mem_req = 1; mem_we = 0; mem_addr = 32'h4000;
    cyc(); bus_ready = 1; bus_rvalid = 1; bus_rdata = 32'h1234;
    half();
    chk("t6_next_addr",  bus_addr, 32'h4000);
    chk("t6_next_ack",   mem_ack, 1);
    chk("t6_next_rdata", mem_rdata, 32'h1234);
    cyc(); mem_req = 0; bus_ready = 0; bus_rvalid = 0;
    half(); chk("t6_idle", bus_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
